// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package hazard_pkg;

  localparam int MULT_LAT_DEF    = 4;
  localparam int DIV_LAT_DEF     = 33;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int WAIT_CNT_W      = 8;
  localparam int PERF_W          = 32;

  typedef enum logic {
    IDLE,
    MD_BUSY
  } md_state_t;

  // One action per cycle, listed lowest to highest priority.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_HAZARD,
    ACT_BRANCH,
    ACT_FREEZE
  } hz_action_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } seg_ctrl_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the sequencer (slave).
interface pipeline_hazard_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [1:0]  id_rt_read;
  logic        id_uses_hilo;
  logic        ex_is_load;
  logic [4:0]  ex_dst;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        ex_md_is_div;
  logic        dmem_req;
  logic        dmem_ready;

  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        md_busy;
  logic        bus_error;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output id_rs, id_rt, id_rt_read, id_uses_hilo, ex_is_load, ex_dst,
           ex_branch_taken, ex_md_start, ex_md_is_div, dmem_req, dmem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush,
           md_busy, bus_error, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rt_read, id_uses_hilo, ex_is_load, ex_dst,
           ex_branch_taken, ex_md_start, ex_md_is_div, dmem_req, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush,
           md_busy, bus_error, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// HI/LO unit occupancy timer: loads latency-1 on issue, counts down to 0, then frees the unit.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments and take the async reset;
  // the countdown keeps running through a pipeline freeze because the unit is not frozen.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        MD_BUSY: begin
          if (start) begin
            cnt <= is_div ? DIV_LOAD : MULT_LOAD;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: freeze, branch flush, hazard bubble,
// plus dmem wait timeout and saturating performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT    = MULT_LAT_DEF,
  parameter int DIV_LAT     = DIV_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic                   Clk,
  input logic                   Rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_M1 = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  logic                  memwait;
  logic                  loaduse;
  logic                  mdhaz;
  logic                  md_issue;
  logic                  md_busy;
  hz_action_t            action;
  seg_ctrl_t             ctrl;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  bus_error_q;
  logic [PERF_W-1:0]     perf_stall_q;
  logic [PERF_W-1:0]     perf_flush_q;

  assign memwait = hz.dmem_req & ~hz.dmem_ready;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign loaduse = hz.ex_is_load && (hz.ex_dst != 5'd0) &&
                   ((hz.id_rt_read[0] && (hz.id_rs == hz.ex_dst)) ||
                    (hz.id_rt_read[1] && (hz.id_rt == hz.ex_dst)));

  assign mdhaz    = hz.id_uses_hilo & (md_busy | hz.ex_md_start);
  assign md_issue = hz.ex_md_start & ~memwait;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_timer (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (md_issue),
    .is_div (hz.ex_md_is_div),
    .busy   (md_busy)
  );

  always_comb begin
    if (memwait)                 action = ACT_FREEZE;
    else if (hz.ex_branch_taken) action = ACT_BRANCH;
    else if (loaduse || mdhaz)   action = ACT_HAZARD;
    else                         action = ACT_NONE;
  end

  // NOTE: default every field first so no path through this block leaves a latch.
  always_comb begin
    ctrl = '0;
    if (Rst) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
    end else begin
      unique case (action)
        ACT_FREEZE: begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_stall  = 1'b1;
          ctrl.ex_mem_stall = 1'b1;
        end
        ACT_BRANCH: begin
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end
        ACT_HAZARD: begin
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_stall = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end
        ACT_NONE: ;
      endcase
    end
  end

  // Wait counter saturates so a stuck bus cannot wrap it back under the threshold.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wait_cnt     <= '0;
      bus_error_q  <= 1'b0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (memwait) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        if (wait_cnt >= TIMEOUT_M1) bus_error_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (ctrl.pc_stall)        perf_stall_q <= sat_inc(perf_stall_q);
      if (action == ACT_BRANCH) perf_flush_q <= sat_inc(perf_flush_q);
    end
  end

  assign hz.pc_stall       = ctrl.pc_stall;
  assign hz.if_id_stall    = ctrl.if_id_stall;
  assign hz.id_ex_stall    = ctrl.id_ex_stall;
  assign hz.ex_mem_stall   = ctrl.ex_mem_stall;
  assign hz.if_id_flush    = ctrl.if_id_flush;
  assign hz.id_ex_flush    = ctrl.id_ex_flush;
  assign hz.ex_mem_flush   = ctrl.ex_mem_flush;
  assign hz.md_busy        = md_busy;
  assign hz.bus_error      = bus_error_q;
  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios then random traffic against a cycle-level model.
module tb_pipeline_hazard_ctrl;

  localparam int MULT_LAT    = 4;
  localparam int DIV_LAT     = 33;
  localparam int MEM_TIMEOUT = 255;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  pipeline_hazard_ctrl_if hz_if ();

  pipeline_hazard_ctrl #(
    .MULT_LAT    (MULT_LAT),
    .DIV_LAT     (DIV_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (hz_if)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining busy cycles of the HI/LO unit, length of current dmem wait run.
  int          m_md_left;
  int          m_wait;
  bit          m_bus_err;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_md_left   = 0;
    m_wait      = 0;
    m_bus_err   = 1'b0;
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
  endtask

  task automatic idle_inputs();
    hz_if.id_rs           = 5'd0;
    hz_if.id_rt           = 5'd0;
    hz_if.id_rt_read      = 2'b00;
    hz_if.id_uses_hilo    = 1'b0;
    hz_if.ex_is_load      = 1'b0;
    hz_if.ex_dst          = 5'd0;
    hz_if.ex_branch_taken = 1'b0;
    hz_if.ex_md_start     = 1'b0;
    hz_if.ex_md_is_div    = 1'b0;
    hz_if.dmem_req        = 1'b0;
    hz_if.dmem_ready      = 1'b0;
  endtask

  function automatic bit mem_waiting();
    return hz_if.dmem_req && !hz_if.dmem_ready;
  endfunction

  // Expected {4 stalls, 3 flushes} from the priority rules.
  function automatic logic [6:0] exp_seg();
    bit reads_rs_hit, reads_rt_hit, dep, hilo_conflict;
    reads_rs_hit  = hz_if.id_rt_read[0] && (hz_if.id_rs == hz_if.ex_dst);
    reads_rt_hit  = hz_if.id_rt_read[1] && (hz_if.id_rt == hz_if.ex_dst);
    dep           = hz_if.ex_is_load && (hz_if.ex_dst != 0) && (reads_rs_hit || reads_rt_hit);
    hilo_conflict = hz_if.id_uses_hilo && ((m_md_left > 0) || hz_if.ex_md_start);
    if (mem_waiting())               return 7'b1111_000;
    else if (hz_if.ex_branch_taken)  return 7'b0000_110;
    else if (dep || hilo_conflict)   return 7'b1100_010;
    else                             return 7'b0000_000;
  endfunction

  function automatic logic [6:0] got_seg();
    return {hz_if.pc_stall, hz_if.if_id_stall, hz_if.id_ex_stall, hz_if.ex_mem_stall,
            hz_if.if_id_flush, hz_if.id_ex_flush, hz_if.ex_mem_flush};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "/seg"},        32'(got_seg()), 32'(7'b0000_111));
    check({tag, "/md_busy"},    32'(hz_if.md_busy), 32'd0);
    check({tag, "/bus_error"},  32'(hz_if.bus_error), 32'd0);
    check({tag, "/perf_stall"}, hz_if.perf_stall_cnt, 32'd0);
    check({tag, "/perf_flush"}, hz_if.perf_flush_cnt, 32'd0);
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    logic [6:0] e;
    @(negedge Clk);
    e = exp_seg();
    check({tag, "/seg"},        32'(got_seg()), 32'(e));
    check({tag, "/md_busy"},    32'(hz_if.md_busy), 32'(m_md_left > 0));
    check({tag, "/bus_error"},  32'(hz_if.bus_error), 32'(m_bus_err));
    check({tag, "/perf_stall"}, hz_if.perf_stall_cnt, m_stall_cnt);
    check({tag, "/perf_flush"}, hz_if.perf_flush_cnt, m_flush_cnt);
    @(posedge Clk);
    if (e[6] && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (!mem_waiting() && hz_if.ex_branch_taken && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    if (hz_if.ex_md_start && !mem_waiting())
      m_md_left = hz_if.ex_md_is_div ? DIV_LAT : MULT_LAT;
    else if (m_md_left > 0)
      m_md_left--;
    if (mem_waiting()) begin
      m_wait++;
      if (m_wait >= MEM_TIMEOUT) m_bus_err = 1'b1;
    end else begin
      m_wait = 0;
    end
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #3;
    check_reset("por");
    @(posedge Clk);
    #1 Rst = 1'b0;

    // Load-use on Rs, then the same pattern targeting r0.
    hz_if.ex_is_load = 1'b1; hz_if.ex_dst = 5'd5; hz_if.id_rs = 5'd5; hz_if.id_rt_read = 2'b01;
    cycle("t1_loaduse");
    hz_if.ex_dst = 5'd0; hz_if.id_rs = 5'd0;
    cycle("t1_r0");
    idle_inputs();
    cycle("t1_idle");

    // Branch outranks a simultaneous load-use.
    hz_if.ex_is_load = 1'b1; hz_if.ex_dst = 5'd7; hz_if.id_rt = 5'd7; hz_if.id_rt_read = 2'b10;
    hz_if.ex_branch_taken = 1'b1;
    cycle("t2_branch");
    idle_inputs();
    cycle("t2_after");

    // DIV issue with a HI/LO reader held in ID for the whole occupancy.
    hz_if.ex_md_start = 1'b1; hz_if.ex_md_is_div = 1'b1; hz_if.id_uses_hilo = 1'b1;
    cycle("t3_issue");
    hz_if.ex_md_start = 1'b0; hz_if.ex_md_is_div = 1'b0;
    for (int i = 0; i < DIV_LAT + 3; i++) cycle("t3_div");
    idle_inputs();

    // MULT issue followed by a 3-cycle dmem freeze; the unit still drains.
    hz_if.ex_md_start = 1'b1;
    cycle("t4_issue");
    hz_if.ex_md_start = 1'b0; hz_if.dmem_req = 1'b1; hz_if.dmem_ready = 1'b0;
    hz_if.id_uses_hilo = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t4_freeze");
    hz_if.dmem_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t4_drain");
    idle_inputs();

    // Long dmem stall trips the sticky bus error.
    hz_if.dmem_req = 1'b1; hz_if.dmem_ready = 1'b0;
    for (int i = 0; i < 256; i++) cycle("t5_wait");
    hz_if.dmem_ready = 1'b1;
    cycle("t5_ready");
    hz_if.dmem_req = 1'b0;
    cycle("t5_after");

    // Random traffic over a small register space so dependencies are frequent.
    for (int i = 0; i < 1200; i++) begin
      hz_if.id_rs           = 5'($urandom_range(0, 3));
      hz_if.id_rt           = 5'($urandom_range(0, 3));
      hz_if.id_rt_read      = 2'($urandom_range(0, 3));
      hz_if.id_uses_hilo    = ($urandom_range(0, 9) < 3);
      hz_if.ex_is_load      = ($urandom_range(0, 9) < 3);
      hz_if.ex_dst          = 5'($urandom_range(0, 3));
      hz_if.ex_branch_taken = ($urandom_range(0, 19) < 3);
      hz_if.ex_md_start     = ($urandom_range(0, 19) < 2);
      hz_if.ex_md_is_div    = 1'($urandom_range(0, 1));
      hz_if.dmem_req        = ($urandom_range(0, 9) < 3);
      hz_if.dmem_ready      = ($urandom_range(0, 9) < 6);
      cycle("rand");
    end
    idle_inputs();

    // Asynchronous reset in the middle of a DIV.
    hz_if.ex_md_start = 1'b1; hz_if.ex_md_is_div = 1'b1;
    cycle("t6_issue");
    hz_if.ex_md_start = 1'b0;
    for (int i = 0; i < 5; i++) cycle("t6_busy");
    Rst = 1'b1;
    #1;
    model_reset();
    check_reset("t6_rst");
    @(posedge Clk);
    #1 Rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t6_post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
